// File: rtl/mem_if.sv
// Memory interface bridge: turns a single read/write command from control into one
// request/response transaction on the memory bus, with response timeout and sticky error.
module mem_if #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] rdata,
  output logic        mdr_valid,
  output logic        busy,
  output logic        err,
  output logic        m_req_valid,
  input  logic        m_req_ready,
  output logic [31:0] m_req_addr,
  output logic        m_req_we,
  output logic [31:0] m_req_wdata,
  output logic [3:0]  m_req_wstrb,
  input  logic        m_rsp_valid,
  input  logic [31:0] m_rsp_data,
  input  logic        m_rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic [31:0] lat_addr;
  logic        lat_we;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wstrb;

  logic cmd_any;
  logic cmd_ok;
  logic timeout_hit;

  assign cmd_any     = mem_read | mem_write;
  assign cmd_ok      = (mem_read ^ mem_write) && (addr[1:0] == 2'b00);
  // The cycle in which the counter reaches TIMEOUT is the last WAIT cycle.
  assign timeout_hit = ((cnt + 8'd1) == TIMEOUT_CNT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (cmd_ok)       state_nxt = REQ;
        else if (cmd_any) state_nxt = DONE;
        else              state_nxt = IDLE;
      end
      REQ:  state_nxt = m_req_ready ? WAIT : REQ;
      WAIT: begin
        if (m_rsp_valid || timeout_hit) state_nxt = DONE;
        else                            state_nxt = WAIT;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latched request fields, counter, read data and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_ok) begin
            lat_addr  <= addr;
            lat_we    <= mem_write;
            lat_wdata <= wdata;
            lat_wstrb <= mem_write ? wstrb : 4'hF;
            err       <= 1'b0;
          end else if (cmd_any) begin
            err <= 1'b1;
          end
        end
        REQ: begin
          if (m_req_ready) cnt <= '0;
        end
        WAIT: begin
          if (m_rsp_valid) begin
            if (!lat_we) rdata <= m_rsp_data;
            err <= m_rsp_err;
          end else begin
            cnt <= cnt + 8'd1;
            if (timeout_hit) err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    m_req_valid = (state == REQ);
    mdr_valid   = (state == DONE);
    busy        = (state != IDLE);
    m_req_addr  = lat_addr;
    m_req_we    = lat_we;
    m_req_wdata = lat_wdata;
    m_req_wstrb = lat_wstrb;
  end

endmodule

// File: tb/tb_mem_if.sv
// Directed bench for mem_if: table of transactions with hand-computed latency and results,
// plus hand-written reset sequences.
module tb_mem_if;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        mdr_valid;
  logic        busy;
  logic        err;
  logic        m_req_valid;
  logic        m_req_ready;
  logic [31:0] m_req_addr;
  logic        m_req_we;
  logic [31:0] m_req_wdata;
  logic [3:0]  m_req_wstrb;
  logic        m_rsp_valid;
  logic [31:0] m_rsp_data;
  logic        m_rsp_err;

  int n_vec  = 0;
  int n_fail = 0;

  mem_if #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .addr        (addr),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .rdata       (rdata),
    .mdr_valid   (mdr_valid),
    .busy        (busy),
    .err         (err),
    .m_req_valid (m_req_valid),
    .m_req_ready (m_req_ready),
    .m_req_addr  (m_req_addr),
    .m_req_we    (m_req_we),
    .m_req_wdata (m_req_wdata),
    .m_req_wstrb (m_req_wstrb),
    .m_rsp_valid (m_rsp_valid),
    .m_rsp_data  (m_rsp_data),
    .m_rsp_err   (m_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sdly == 255 means the memory never responds
  typedef struct {
    logic        rd;
    logic        wr;
    logic        legal;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  exp_wstrb;
    int unsigned rdly;
    int unsigned sdly;
    logic        early;
    logic [31:0] rsp_data;
    logic        rsp_err;
    int unsigned lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Entered at #1 after a rising edge with the DUT idle; returns at the same phase, idle again.
  task automatic run_vec(input vec_t v, input int idx);
    logic exp_rv;
    chk($sformatf("v%0d_idle_busy", idx), {31'd0, busy}, 32'd0);
    mem_read  = v.rd;
    mem_write = v.wr;
    addr      = v.addr;
    wdata     = v.wdata;
    wstrb     = v.wstrb;
    for (int unsigned c = 1; c <= v.lat + 1; c++) begin
      @(posedge clk); #1;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      addr        = 32'hFFFF_FFFF;
      wdata       = 32'hFFFF_FFFF;
      wstrb       = 4'h0;
      m_req_ready = 1'b0;
      m_rsp_valid = 1'b0;
      m_rsp_err   = 1'b0;
      m_rsp_data  = 32'h0;
      exp_rv = v.legal && (c <= 1 + v.rdly);
      chk($sformatf("v%0d_c%0d_req_valid", idx, c), {31'd0, m_req_valid}, {31'd0, exp_rv});
      if (exp_rv) begin
        chk($sformatf("v%0d_c%0d_req_addr", idx, c), m_req_addr, v.addr);
        chk($sformatf("v%0d_c%0d_req_we", idx, c), {31'd0, m_req_we}, {31'd0, v.wr});
        chk($sformatf("v%0d_c%0d_req_wdata", idx, c), m_req_wdata, v.wdata);
        chk($sformatf("v%0d_c%0d_req_wstrb", idx, c), {28'd0, m_req_wstrb}, {28'd0, v.exp_wstrb});
      end
      if (v.legal && c == 1)
        chk($sformatf("v%0d_err_clr", idx), {31'd0, err}, 32'd0);
      chk($sformatf("v%0d_c%0d_mdr_valid", idx, c), {31'd0, mdr_valid}, {31'd0, (c == v.lat)});
      chk($sformatf("v%0d_c%0d_busy", idx, c), {31'd0, busy}, {31'd0, (c <= v.lat)});
      if (c >= v.lat) begin
        chk($sformatf("v%0d_c%0d_rdata", idx, c), rdata, v.exp_rdata);
        chk($sformatf("v%0d_c%0d_err", idx, c), {31'd0, err}, {31'd0, v.exp_err});
      end
      if (v.legal && c == 1 + v.rdly) begin
        m_req_ready = 1'b1;
        if (v.early) begin
          m_rsp_valid = 1'b1;
          m_rsp_data  = 32'hBAD0_BAD0;
          m_rsp_err   = 1'b1;
        end
      end
      if (v.legal && v.sdly != 255 && c == 2 + v.rdly + v.sdly) begin
        m_rsp_valid = 1'b1;
        m_rsp_data  = v.rsp_data;
        m_rsp_err   = v.rsp_err;
      end
    end
    m_req_ready = 1'b0;
    m_rsp_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},      {31'd0, busy},        32'd0);
    chk({tag, "_mdr_valid"}, {31'd0, mdr_valid},   32'd0);
    chk({tag, "_req_valid"}, {31'd0, m_req_valid}, 32'd0);
    chk({tag, "_err"},       {31'd0, err},         32'd0);
    chk({tag, "_rdata"},     rdata,                32'd0);
    chk({tag, "_req_addr"},  m_req_addr,           32'd0);
    chk({tag, "_req_wdata"}, m_req_wdata,          32'd0);
    chk({tag, "_req_we"},    {31'd0, m_req_we},    32'd0);
    chk({tag, "_req_wstrb"}, {28'd0, m_req_wstrb}, 32'd0);
  endtask

  initial begin
    //          rd  wr  ok  addr          wdata         wstrb exp  rdly sdly early rsp_data      rerr lat exp_rdata     exp_err
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h100, 32'h0,        4'h5, 4'hF, 0, 0,   1'b0, 32'hDEADBEEF, 1'b0, 3, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h200, 32'h12345678, 4'h3, 4'h3, 5, 1,   1'b0, 32'hFFFF0000, 1'b0, 9, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h300, 32'h0,        4'h5, 4'hF, 0, 255, 1'b0, 32'h0,        1'b0, 6, 32'hDEADBEEF, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h0,   32'h0,        4'h5, 4'hF, 0, 0,   1'b0, 32'h11,       1'b0, 3, 32'h11,       1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h4,   32'h0,        4'h5, 4'hF, 1, 2,   1'b1, 32'h44,       1'b0, 6, 32'h44,       1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h103, 32'h0,        4'h5, 4'hF, 0, 0,   1'b0, 32'h0,        1'b0, 1, 32'h44,       1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h400, 32'h0,        4'h5, 4'hF, 0, 0,   1'b0, 32'h0,        1'b0, 1, 32'h44,       1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h8,   32'hA5A5A5A5, 4'h8, 4'h8, 0, 0,   1'b0, 32'h99,       1'b1, 3, 32'h44,       1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'hC,   32'h0,        4'h5, 4'hF, 2, 3,   1'b0, 32'hCAFEF00D, 1'b0, 8, 32'hCAFEF00D, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h10,  32'h0,        4'h5, 4'hF, 0, 3,   1'b0, 32'h55,       1'b0, 6, 32'h55,       1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h14,  32'h0,        4'h5, 4'hF, 0, 4,   1'b0, 32'hBB,       1'b1, 6, 32'h55,       1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 32'h20,  32'h0,        4'h5, 4'hF, 0, 0,   1'b0, 32'h77,       1'b0, 3, 32'h77,       1'b0};

    rst_n       = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    addr        = '0;
    wdata       = '0;
    wstrb       = '0;
    m_req_ready = 1'b0;
    m_rsp_valid = 1'b0;
    m_rsp_data  = '0;
    m_rsp_err   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst_n = 1'b1;

    // The first command is presented right as reset releases
    for (int i = 0; i <= 10; i++) run_vec(vecs[i], i);

    // Reset pulsed mid-WAIT, then a late response arrives while idle
    mem_read = 1'b1;
    addr     = 32'h40;
    @(posedge clk); #1;
    mem_read    = 1'b0;
    m_req_ready = 1'b1;
    @(posedge clk); #1;
    m_req_ready = 1'b0;
    @(posedge clk); #1;
    chk("wait_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_wait");
    #1;
    rst_n       = 1'b1;
    m_rsp_valid = 1'b1;
    m_rsp_data  = 32'h5A5A_5A5A;
    m_rsp_err   = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("late_rsp1");
    @(posedge clk); #1;
    m_rsp_valid = 1'b0;
    m_rsp_err   = 1'b0;
    chk_reset_outputs("late_rsp2");

    // Short reset pulse, command accepted on the first edge after release
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    run_vec(vecs[11], 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
